mem_readback_streamer: RTL

- Reader-side companion to the team's block-RAM `memory` wrapper.
- Sweeps an address range on the RAM read port and streams each word out on a valid/ready interface, with address tag and last flag.
- Accumulates a running checksum so bitstream-reinit tests can compare RAM contents against the expected `.init` image.
- Sits between the RAM's raddr/dout pins and the test harness or readback logic.

---
 rtl/mem_readback_pkg.sv | 12 +
 rtl/mem_readback_streamer_skid_buf.sv | 39 +++
 rtl/mem_readback_streamer.sv | 92 +++++++++
 3 files changed

// File: rtl/mem_readback_pkg.sv
// mem_readback_pkg: shared types and default widths for the readback streamer
package mem_readback_pkg;
  localparam int WID_MEM = 18;
  localparam int ADDR_W = 13;
  localparam int CSUM_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [WID_MEM-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic last;
  } entry_t;
endpackage

// File: rtl/mem_readback_streamer_skid_buf.sv
// readback_skid_buf: two-entry FIFO of readback entries with flush
module readback_skid_buf import mem_readback_pkg::*; (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic push,
  input logic pop,
  input entry_t din,
  output entry_t dout,
  output logic [1:0] count,
  output logic full,
  output logic empty
);
  entry_t mem [2];
  logic wp, rp, do_push, do_pop;
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  // storage and pointers; clear drops every buffered entry
  always_ff @(posedge clk)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else if (clr) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) mem[wp] <= din;
      wp <= wp ^ do_push;
      rp <= rp ^ do_pop;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
endmodule

// File: rtl/mem_readback_streamer.sv
// mem_readback_streamer: sweeps a RAM address range and streams words with a running checksum
module mem_readback_streamer #(
  parameter int WID_MEM = mem_readback_pkg::WID_MEM,
  parameter int ADDR_W = mem_readback_pkg::ADDR_W,
  parameter int DEPTH_MEM = 8192,
  parameter int CSUM_W = mem_readback_pkg::CSUM_W
) (
  input logic clk,
  input logic reset,
  input logic start,
  input logic abort,
  input logic [ADDR_W-1:0] first_addr,
  input logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] mem_raddr,
  input logic [WID_MEM-1:0] mem_dout,
  output logic m_valid,
  input logic m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic m_last,
  output logic busy,
  output logic done,
  output logic [CSUM_W-1:0] checksum
);
  import mem_readback_pkg::*;
  state_t state, state_n;
  entry_t head, din;
  logic [ADDR_W:0] rem;
  logic [ADDR_W-1:0] raddr_n, inflight_addr;
  logic [1:0] count;
  logic [2:0] credits;
  logic inflight, inflight_last, empty, full, xfer, issue, accept;
  assign busy = state != IDLE;
  assign m_valid = !empty;
  assign m_data = head.data;
  assign m_addr = head.addr;
  assign m_last = head.last;
  assign din = '{data: mem_dout, addr: inflight_addr, last: inflight_last};
  readback_skid_buf u_buf (
    .clk(clk),
    .rst(reset),
    .clr(abort && busy),
    .push(inflight && !full),
    .pop(xfer),
    .din(din),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // handshake, credit check and next state; a read is issued only if its word is sure to fit
  always_comb begin
    xfer = m_valid && m_ready;
    accept = state == IDLE && start && !abort;
    credits = {1'b0, count} + {2'b0, inflight} - {2'b0, xfer};
    issue = state == RUN && !abort && credits < 3'd2;
    raddr_n = mem_raddr == ADDR_W'(DEPTH_MEM - 1) ? '0 : mem_raddr + 1'b1;
    state_n = abort && busy ? IDLE :
              accept ? RUN :
              issue && rem == (ADDR_W+1)'(1) ? DRAIN :
              state == DRAIN && xfer && head.last ? IDLE : state;
  end
  // state, address counter, in-flight tracking and checksum
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      mem_raddr <= '0;
      rem <= '0;
      inflight <= 1'b0;
      inflight_addr <= '0;
      inflight_last <= 1'b0;
      checksum <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= state == DRAIN && xfer && head.last && !abort;
      inflight <= issue;
      if (accept) begin
        mem_raddr <= first_addr;
        rem <= {1'b0, last_addr - first_addr} + 1'b1;
        checksum <= '0;
      end else begin
        if (issue) begin
          mem_raddr <= raddr_n;
          rem <= rem - 1'b1;
          inflight_addr <= mem_raddr;
          inflight_last <= rem == (ADDR_W+1)'(1);
        end
        if (xfer) checksum <= checksum + CSUM_W'(m_data);
      end
    end
endmodule
